// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared state encoding and frame constants for the
// framed serial transmitter seq_gen.
package seq_gen_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      DATA,
      PAR,
      GAP
   } gen_state_t;

   localparam logic [2:0] PREAMBLE = 3'b101;
   localparam int PRE_LEN = 3;

   // One counter serves preamble, data and gap phases.
   function automatic int cnt_width(input int data_w);
      return $clog2(((data_w > PRE_LEN) ? data_w : PRE_LEN) + 1);
   endfunction

endpackage

// File: rtl/seq_gen_piso.sv
// seq_gen_piso: parallel-in/serial-out shift register, MSB first.
// Load has priority over shift.
module seq_gen_piso #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb
);

   logic [W-1:0] sr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr <= '0;
      end else if (load) begin
         sr <= din;
      end else if (shift) begin
         sr <= sr << 1;
      end
   end

   assign msb = sr[W-1];

endmodule

// File: rtl/seq_gen.sv
// seq_gen: framed serial transmitter (preamble 1-0-1, MSB-first data,
// idle gap). Define SEQ_GEN_PARITY_EN to append an even-parity bit.
module seq_gen
   import seq_gen_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              dout,
   output logic              dout_valid,
   output logic              busy,
   output logic              frame_done
);

   localparam int CW = cnt_width(DATA_W);
   localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

   if (DATA_W < 1) begin : g_dw_chk
      $error("seq_gen: DATA_W must be >= 1");
   end
   if (GAP_CYCLES < 1) begin : g_gap_chk
      $error("seq_gen: GAP_CYCLES must be >= 1");
   end
   if (GAP_CYCLES > (1 << CW)) begin : g_gap_fit
      $error("seq_gen: GAP_CYCLES exceeds counter range");
   end

`ifdef SEQ_GEN_PARITY_EN
   localparam gen_state_t AFTER_DATA = PAR;
`else
   localparam gen_state_t AFTER_DATA = GAP;
`endif

   gen_state_t    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          load, shift, msb, par;

   seq_gen_piso #(.W(DATA_W)) u_piso (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .shift (shift),
      .din   (in_data),
      .msb   (msb)
   );

`ifdef SEQ_GEN_PARITY_EN
   // Parity is taken at acceptance since the shifter loses the word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         par <= 1'b0;
      end else if (load) begin
         par <= ^in_data;
      end
   end
`else
   assign par = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      load      = 1'b0;
      shift     = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               load      = 1'b1;
               cnt_nxt   = '0;
               state_nxt = PRE;
            end
         end
         PRE: begin
            if (cnt == PRE_LAST) begin
               cnt_nxt   = '0;
               state_nxt = DATA;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DATA: begin
            shift = 1'b1;
            if (cnt == DATA_LAST) begin
               cnt_nxt   = '0;
               state_nxt = AFTER_DATA;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         PAR: begin
            cnt_nxt   = '0;
            state_nxt = GAP;
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      dout       = 1'b0;
      dout_valid = 1'b0;
      frame_done = 1'b0;
      unique case (state)
         PRE: begin
            dout       = PREAMBLE[2'(PRE_LEN - 1) - cnt[1:0]];
            dout_valid = 1'b1;
         end
         DATA: begin
            dout       = msb;
            dout_valid = 1'b1;
         end
         PAR: begin
            dout       = par;
            dout_valid = 1'b1;
         end
         GAP: begin
            frame_done = (cnt == GAP_LAST);
         end
         default: begin
            dout = 1'b0;
         end
      endcase
   end

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: randomized and directed bench for seq_gen against a
// queue-based frame model.
module tb_seq_gen;

   localparam int DW   = 8;
   localparam int GAPC = 2;
`ifdef SEQ_GEN_PARITY_EN
   localparam int P = 1;
   localparam logic [3+DW:0] A5_FRAME = 12'b101_10100101_0;
`else
   localparam int P = 0;
   localparam logic [2+DW:0] A5_FRAME = 11'b101_10100101;
`endif
   localparam int F      = 3 + DW + P;
   localparam int PERIOD = 1 + F + GAPC;
   localparam int LOGN   = 8192;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data  = '0;
   logic          in_ready, dout, dout_valid, busy, frame_done;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int acc_n  = 0;
   int last_first = 0;

   typedef struct packed {
      logic bit_v;
      logic vld;
      logic done;
   } beat_t;

   beat_t q[$];
   beat_t ce;
   logic  cer, ceb;

   logic lg_dout [LOGN];
   logic lg_vld  [LOGN];
   logic lg_done [LOGN];
   logic lg_busy [LOGN];
   logic lg_rdy  [LOGN];

   seq_gen #(.DATA_W(DW), .GAP_CYCLES(GAPC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   function automatic void push_frame(input logic [DW-1:0] w);
      logic [2:0] pre;
      int ones;
      pre  = 3'b101;
      ones = 0;
      for (int i = 0; i < 3; i++) q.push_back('{pre[2-i], 1'b1, 1'b0});
      for (int i = DW - 1; i >= 0; i--) begin
         q.push_back('{w[i], 1'b1, 1'b0});
         ones += int'(w[i]);
      end
      if (P == 1) q.push_back('{ones[0], 1'b1, 1'b0});
      for (int i = 0; i < GAPC; i++) q.push_back('{1'b0, 1'b0, (i == GAPC - 1)});
   endfunction

   // Model: one queue entry per cycle of the frame in flight.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) q.delete();
      else if (q.size() > 0) void'(q.pop_front());
      else if (in_valid) begin
         push_frame(in_data);
         acc_n++;
         last_first = cyc;
      end
   end

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         ce = q[0]; cer = 1'b0; ceb = 1'b1;
      end else begin
         ce = '0; cer = 1'b1; ceb = 1'b0;
      end
      checks++;
      if ({dout, dout_valid, frame_done, busy, in_ready} !==
          {ce.bit_v, ce.vld, ce.done, ceb, cer}) begin
         errors++;
         $display("FAIL cycle_model cyc=%0d got d/v/done/busy/rdy=%b%b%b%b%b exp=%b%b%b%b%b",
                  cyc, dout, dout_valid, frame_done, busy, in_ready,
                  ce.bit_v, ce.vld, ce.done, ceb, cer);
      end
      if (cyc < LOGN) begin
         lg_dout[cyc] = dout;
         lg_vld[cyc]  = dout_valid;
         lg_done[cyc] = frame_done;
         lg_busy[cyc] = busy;
         lg_rdy[cyc]  = in_ready;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [DW-1:0] w, input logic hold, output int first);
      int start;
      bit ok;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      start    = acc_n;
      ok       = 1'b0;
      for (int i = 0; i < 4 * PERIOD && !ok; i++) begin
         @(posedge clk);
         #2;
         if (acc_n != start) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout word=%0h got=no_accept exp=accept", w);
      end
      first = last_first;
      if (!hold) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   function automatic logic [31:0] word_at(input int c, input int n);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < n; k++) r = {r[30:0], lg_dout[c+k]};
      return r;
   endfunction

   function automatic logic [31:0] vld_at(input int c, input int n);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < n; k++) r = {r[30:0], lg_vld[c+k]};
      return r;
   endfunction

   initial begin
      int f, f1, f2, g, c, nd, fd;
      logic any, ok_idle;

      tick(3);
      rst_n = 1'b1;
      c = cyc;
      tick(10);
      ok_idle = 1'b1;
      for (int k = c + 1; k <= c + 10; k++)
         if (!(lg_rdy[k] === 1'b1 && lg_busy[k] === 1'b0 &&
               lg_vld[k] === 1'b0 && lg_dout[k] === 1'b0)) ok_idle = 1'b0;
      chk("idle_hold", ok_idle, 1);

      send(8'hA5, 1'b0, f);
      tick(PERIOD + 2);
      chk("a5_latency", {lg_rdy[f-1], lg_rdy[f], lg_vld[f-1], lg_vld[f]}, 4'b1001);
      chk("a5_frame", word_at(f, F), 32'(A5_FRAME));
      chk("a5_valid", vld_at(f, F), (32'd1 << F) - 1);
      chk("a5_gap_vld", {lg_vld[f+F], lg_vld[f+F+1]}, 2'b00);
      chk("a5_done", {lg_done[f+F-1], lg_done[f+F], lg_done[f+F+1]}, 3'b001);

`ifdef SEQ_GEN_PARITY_EN
      send(8'h07, 1'b0, f);
      tick(PERIOD + 2);
      chk("par07_frame", word_at(f, F), 32'b1010_0000_1111);
      chk("par07_bit", lg_dout[f+F-1], 1);
      send(8'h03, 1'b0, f);
      tick(PERIOD + 2);
      chk("par03_bit", lg_dout[f+F-1], 0);
`endif

      send(8'hFF, 1'b1, f1);
      send(8'h00, 1'b1, f2);
      in_valid = 1'b0;
      tick(PERIOD + 2);
      c = f1;
      while (c < f1 + 4 * PERIOD && lg_rdy[c] !== 1'b1) c++;
      chk("b2b_dut_period", c + 1 - f1, PERIOD);
      chk("b2b_period_14", c + 1 - f1, (P == 1) ? 15 : 14);
      chk("b2b_f1_data", word_at(f1 + 3, DW), 32'hFF);
      chk("b2b_f2_data", word_at(f2 + 3, DW), 32'h00);

      send(DW'($urandom), 1'b0, f);
      while (cyc < f + 7) @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      c        = cyc;
      tick(2);
      rst_n    = 1'b0;
      tick(0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      tick(PERIOD + 4);
      chk("rst_after_edge", {lg_vld[c+1], lg_busy[c+1]}, 2'b00);
      chk("rst_ready", {lg_rdy[c+1], lg_rdy[c+3]}, 2'b11);
      any = 1'b0;
      for (int k = f; k < c + PERIOD; k++) any |= lg_done[k];
      chk("rst_no_done", any, 0);
      send(8'h3C, 1'b0, g);
      tick(PERIOD + 2);
      chk("rst_clean_pre", word_at(g, 3), 3'b101);
      chk("rst_new_frame", word_at(g + 3, DW), 32'h3C);

      send(8'h00, 1'b1, g);
      for (int n = 0; n < 3; n++) send(8'h00, 1'b1, f);
      in_valid = 1'b0;
      tick(PERIOD + 2);
      nd = 0;
      fd = -1;
      for (int k = g; k < g + 4 * PERIOD; k++)
         if (lg_dout[k-2] === 1'b1 && lg_dout[k-1] === 1'b0 && lg_dout[k] === 1'b1) begin
            nd++;
            if (fd < 0) fd = k;
         end
      chk("det_count", nd, 4);
      chk("det_align", fd - g, 2);

      for (int k = 0; k < 2500; k++) begin
         @(negedge clk);
         in_valid = ($urandom_range(0, 2) != 0);
         in_data  = DW'($urandom);
         rst_n    = ($urandom_range(0, 79) != 0);
      end
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      tick(PERIOD + 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial framed-pattern transmitter for the FSM lesson set. It accepts a parallel data word over a valid/ready handshake and emits it one bit per clock, MSB first, on a single-bit line. Each frame is prefixed with the fixed sync preamble 1→0→1, so the downstream 1-0-1 sequence detector can lock onto frame starts. Frames are separated by a guaranteed idle gap.

## Interface
- `DATA_W`, default 8: payload width in bits; must be ≥ 1.
- `GAP_CYCLES`, default 2: idle cycles after each frame; must be ≥ 1. An elaboration-time check fails if it is 0.
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `in_valid`, input, 1: `in_data` is offered.
- `in_ready`, output, 1: the block can accept a word.
- `in_data`, input, `DATA_W`: payload word.
- `dout`, output, 1: serial bit stream. Driven 0 when not transmitting.
- `dout_valid`, output, 1: `dout` carries a frame bit (preamble, data, or parity).
- `busy`, output, 1: FSM is not in IDLE.
- `frame_done`, output, 1: one-cycle pulse on the final gap cycle.

## Operation
- FSM states: IDLE, PRE, DATA, PAR, GAP.
- IDLE
  - `in_ready`=1.
  - On `in_valid && in_ready` at a clock edge: load `in_data` into the shift register, clear the bit counter, go to PRE.
- PRE
  - Emits the preamble bits 1, 0, 1 on successive cycles with `dout_valid`=1.
  - After the third bit, go to DATA.
- DATA
  - Emits `in_data[DATA_W-1]` down to `in_data[0]`, one bit per cycle, with `dout_valid`=1.
  - After the last bit, go to PAR if parity is compiled in, otherwise to GAP.
- PAR
  - Emits the even-parity bit, `^data`, for one cycle with `dout_valid`=1.
  - Then go to GAP.
- GAP
  - `dout`=0 and `dout_valid`=0 for `GAP_CYCLES` cycles.
  - `frame_done`=1 on the last of those cycles.
  - Then go to IDLE.
- `in_ready` is 1 only in IDLE. `in_valid` is ignored in all other states.
- The word is captured at acceptance. Later changes to `in_data` do not affect the frame in flight.
- Counter width is `$clog2(max(DATA_W,3)+1)`. The counter is reused by PRE, DATA and GAP and cleared on each state entry.
- Reset, including mid-frame:
  - The next edge with `rst_n`=0 forces IDLE and clears the shift register and counter.
  - The frame is abandoned; no partial frame or parity is sent.
  - `dout`=0, `dout_valid`=0, `busy`=0, `frame_done`=0.
  - `in_ready`=1 from the first cycle after that edge.
  - Handshakes presented while `rst_n`=0 are not accepted.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `busy`=0, `frame_done`=0, `in_ready`=1.
- All outputs are decoded from registered state, shift register and counter only. There is no combinational path from `in_valid` or `in_data` to any output.
- Latency: the accept edge is cycle 0. The first preamble bit appears on `dout` in cycle 1.
- Frame length F = 3 + `DATA_W` + P bits, where P = 1 with parity and 0 without.
- Minimum accept-to-accept period = 1 + F + `GAP_CYCLES`.
  - Default, no parity: 14 cycles.
  - With an upstream that holds `in_valid` high, frames repeat at exactly this period.
- `busy` is 1 from cycle 1 through the final GAP cycle.

## Configuration
- `SEQ_GEN_PARITY_EN` defined: the PAR state is present and one even-parity bit follows the data. F = `DATA_W` + 4.
- Not defined: the PAR state and parity logic are not compiled. DATA goes directly to GAP. F = `DATA_W` + 3.

## Structure
- Package `seq_gen_pkg`:
  - `gen_state_t` enum {IDLE, PRE, DATA, PAR, GAP}. PAR is kept in the enum unconditionally.
  - `PREAMBLE` = 3'b101 and `PRE_LEN` = 3.
- One sub-module, `seq_gen_piso`: a parameterized parallel-in/serial-out shift register with `load`, `shift` and `msb` out. The top FSM drives `load` and `shift`.

## Test plan
- Reset, then hold `in_valid`=0 for 10 cycles → `in_ready`=1, `dout`=0, `dout_valid`=0, `busy`=0 throughout.
- Send `in_data`=8'hA5, no parity → cycles 1–11 show `dout` = 1,0,1,1,0,1,0,0,1,0,1 with `dout_valid`=1. Cycles 12–13 show `dout_valid`=0. `frame_done`=1 in cycle 13 only.
- With `SEQ_GEN_PARITY_EN`, send 8'h07 → 12 valid bits ending 0,0,0,0,0,1,1,1,1. The final parity bit is 1. Repeat with 8'h03 → final parity bit is 0.
- Hold `in_valid`=1 with words 8'hFF then 8'h00 → second acceptance occurs exactly 14 cycles after the first. `in_data` changes between acceptances do not alter the frame in flight.
- Assert `rst_n`=0 at data bit 4, hold 2 cycles → `dout_valid`=0 and `busy`=0 after the first reset edge. No `frame_done` pulse. `in_ready`=1 after release, and a new frame starts with a clean preamble.
- Loopback into the 1-0-1 detector with 8'h00 payloads → exactly one `detected` pulse per frame, aligned to the preamble.
